// File: rtl/rpn_token_parser_if.sv
// Byte-stream input and calculator apply-strobe output of the RPN token parser.
// slave is the parser's side of the bus; master is the side that feeds it and watches the strobes.
interface rpn_token_parser_if #(
    parameter int unsigned WIDTH = 8
);
    logic [7:0]       in_byte;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic [2:0]       out_op;
    logic             out_apply;

    modport slave (
        input  in_byte,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_op,
        output out_apply
    );

    modport master (
        output in_byte,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_op,
        input  out_apply
    );
endinterface

// File: rtl/rpn_token_parser.sv
// Parses an ASCII reverse-Polish token stream into calculator apply strobes (push literal / op code).
// Decimal literals accumulate with overflow detection; invalid input and overflow set a sticky err.
module rpn_token_parser #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    rpn_token_parser_if.slave   bus,
    output logic                err,
    output logic                busy
);
    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_NUM       = 2'd1;
    localparam logic [1:0] S_EMIT_PUSH = 2'd2;
    localparam logic [1:0] S_EMIT_OP   = 2'd3;

    logic [1:0]       state, state_d;
    logic [WIDTH-1:0] acc, acc_d;
    logic             ovf, ovf_d;
    logic             op_pend, op_pend_d;
    logic [2:0]       op_code, op_code_d;
    logic             err_q, err_d;
    logic             apply_q, apply_d;
    logic [2:0]       out_op_q, out_op_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;

    logic             is_digit;
    logic             is_sep;
    logic             is_op;
    logic [2:0]       op_dec;
    logic [3:0]       digit;
    logic [WIDTH+3:0] prod;
    logic             prod_ovf;
    logic             accept;

    assign bus.in_ready  = (state == S_IDLE) || (state == S_NUM);
    assign bus.out_apply = apply_q;
    assign bus.out_op    = out_op_q;
    assign bus.out_data  = out_data_q;
    assign err           = err_q;
    assign busy          = (state != S_IDLE);

    assign accept = bus.in_valid && bus.in_ready;

    always_comb begin
        is_digit = (bus.in_byte >= 8'h30) && (bus.in_byte <= 8'h39);
        is_sep   = (bus.in_byte == 8'h20) || (bus.in_byte == 8'h0A) || (bus.in_byte == 8'h0D);
        digit    = bus.in_byte[3:0];
        is_op    = 1'b1;
        op_dec   = 3'd0;
        case (bus.in_byte)
            8'h64:   op_dec = 3'd1;   // 'd'
            8'h2B:   op_dec = 3'd2;   // '+'
            8'h2A:   op_dec = 3'd3;   // '*'
            8'h2D:   op_dec = 3'd4;   // '-'
            8'h2F:   op_dec = 3'd5;   // '/'
            8'h25:   op_dec = 3'd6;   // '%'
            default: is_op = 1'b0;
        endcase
    end

    // Four extra bits hold (2^WIDTH-1)*10+9 without wrapping.
    assign prod     = {4'b0000, acc} * (WIDTH + 4)'(10) + {{WIDTH{1'b0}}, digit};
    assign prod_ovf = |prod[WIDTH+3:WIDTH];

    // Output registers load on the transition into an emit state so strobes line up with those states.
    always_comb begin
        state_d    = state;
        acc_d      = acc;
        ovf_d      = ovf;
        op_pend_d  = op_pend;
        op_code_d  = op_code;
        err_d      = err_q;
        apply_d    = 1'b0;
        out_op_d   = '0;
        out_data_d = '0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (is_digit) begin
                        acc_d   = WIDTH'(digit);
                        ovf_d   = 1'b0;
                        state_d = S_NUM;
                    end else if (is_op) begin
                        op_code_d = op_dec;
                        op_pend_d = 1'b0;
                        state_d   = S_EMIT_OP;
                        apply_d   = 1'b1;
                        out_op_d  = op_dec;
                    end else if (!is_sep) begin
                        err_d = 1'b1;
                    end
                end
            end
            S_NUM: begin
                if (accept) begin
                    if (is_digit) begin
                        if (!ovf) begin
                            if (prod_ovf) ovf_d = 1'b1;
                            else          acc_d = prod[WIDTH-1:0];
                        end
                    end else if (is_sep) begin
                        if (ovf) begin
                            err_d   = 1'b1;
                            acc_d   = '0;
                            ovf_d   = 1'b0;
                            state_d = S_IDLE;
                        end else begin
                            op_pend_d  = 1'b0;
                            state_d    = S_EMIT_PUSH;
                            apply_d    = 1'b1;
                            out_data_d = acc;
                        end
                    end else if (is_op) begin
                        op_code_d = op_dec;
                        if (ovf) begin
                            err_d     = 1'b1;
                            acc_d     = '0;
                            ovf_d     = 1'b0;
                            op_pend_d = 1'b0;
                            state_d   = S_EMIT_OP;
                            apply_d   = 1'b1;
                            out_op_d  = op_dec;
                        end else begin
                            op_pend_d  = 1'b1;
                            state_d    = S_EMIT_PUSH;
                            apply_d    = 1'b1;
                            out_data_d = acc;
                        end
                    end else begin
                        err_d   = 1'b1;
                        acc_d   = '0;
                        ovf_d   = 1'b0;
                        state_d = S_IDLE;
                    end
                end
            end
            S_EMIT_PUSH: begin
                if (op_pend) begin
                    op_pend_d = 1'b0;
                    state_d   = S_EMIT_OP;
                    apply_d   = 1'b1;
                    out_op_d  = op_code;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_EMIT_OP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            acc        <= '0;
            ovf        <= 1'b0;
            op_pend    <= 1'b0;
            op_code    <= '0;
            err_q      <= 1'b0;
            apply_q    <= 1'b0;
            out_op_q   <= '0;
            out_data_q <= '0;
        end else begin
            state      <= state_d;
            acc        <= acc_d;
            ovf        <= ovf_d;
            op_pend    <= op_pend_d;
            op_code    <= op_code_d;
            err_q      <= err_d;
            apply_q    <= apply_d;
            out_op_q   <= out_op_d;
            out_data_q <= out_data_d;
        end
    end
endmodule

// File: doc/rpn_token_parser.md
Name: rpn_token_parser

Overview:
- Upstream feeder for the queue calculator stage (in/op/apply interface).
- Consumes an ASCII byte stream of reverse-Polish tokens over a valid/ready handshake.
- Accumulates decimal literals, then issues one-cycle apply strobes carrying op codes and push data to the calculator.
- Also reports parse errors.

Parameters:
- WIDTH, 8, data width of literals and of out_data; literals are unsigned and range 0..2^WIDTH-1.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_byte  input  8  ASCII character.
- in_valid  input  1  in_byte is valid this cycle.
- in_ready  output  1  parser accepts in_byte this cycle.
- out_data  output  WIDTH  literal value for push (op 0); 0 for other ops.
- out_op  output  3  calculator op code.
- out_apply  output  1  one-cycle strobe; out_op and out_data are valid only while it is high.
- err  output  1  sticky parse/overflow error flag.
- busy  output  1  high while a literal is being accumulated or an emit is pending.

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - state=IDLE, acc=0, ovf=0.
  - in_ready=1, out_apply=0, out_op=0, out_data=0, err=0, busy=0.
  - Any partially accumulated literal or pending emit is dropped.
- Handshake:
  - A byte is accepted on a rising edge when in_valid && in_ready.
  - in_ready=1 only in IDLE and NUM; it is 0 in EMIT_PUSH and EMIT_OP.
- Character classes:
  - Digits '0'..'9'.
  - Separators: space 0x20, LF 0x0A, CR 0x0D.
  - Operators, mapped to op codes:
    - 'd' -> 1 (drop)
    - '+' -> 2
    - '*' -> 3
    - '-' -> 4
    - '/' -> 5
    - '%' -> 6
  - Everything else is invalid.
- FSM states: IDLE, NUM, EMIT_PUSH, EMIT_OP.
- IDLE:
  - Digit: acc<=digit, ovf<=0, go to NUM.
  - Operator: latch op code, go to EMIT_OP.
  - Separator: stay in IDLE.
  - Invalid: err<=1, stay in IDLE.
- NUM:
  - Digit: acc<=acc*10+digit, computed at WIDTH+4 bits. If the result exceeds 2^WIDTH-1, ovf<=1 and acc is held; ovf stays set until the literal ends.
  - Separator, ovf=0: go to EMIT_PUSH.
  - Separator, ovf=1: err<=1, literal discarded, go to IDLE.
  - Operator, ovf=0: latch op code, go to EMIT_PUSH; EMIT_OP follows.
  - Operator, ovf=1: err<=1, literal discarded, go to EMIT_OP; the operator is still issued.
  - Invalid: err<=1, literal discarded, go to IDLE.
- EMIT_PUSH:
  - Drives out_apply=1, out_op=0, out_data=acc for exactly one cycle.
  - Next state is EMIT_OP if an operator is pending, otherwise IDLE.
- EMIT_OP:
  - Drives out_apply=1, out_op=latched code, out_data=0 for exactly one cycle.
  - Next state is IDLE.
- Outputs are registered. A separator accepted at edge N produces the push strobe high during cycle N+1.
- Literal immediately followed by an operator (e.g. "7*"):
  - Push strobe in cycle N+1, op strobe in cycle N+2.
  - in_ready is low in cycles N+1 and N+2.
  - Back-to-back strobes are legal for the calculator.
- A standalone operator accepted at edge N strobes in cycle N+1.
- Leading zeros are legal ("007" pushes 7).
- End of stream with the FSM in NUM: no push until a separator or operator arrives.
- The parser does not track calculator stack depth. Stack underflow and divide-by-zero are the calculator's valid output to report, not err.
- err is set only by invalid characters and literal overflow. It is cleared only by reset.
- busy = (state != IDLE).

Test Plan:
- Stream "12 34 +\n", in_valid held high -> three strobes: (op0, data 12), (op0, data 34), (op2, data 0); err=0; each strobe exactly one cycle.
- Stream "7*" -> push strobe (op0, 7) followed the next cycle by (op3, 0); in_ready=0 during both strobe cycles, 1 afterwards.
- WIDTH=8, stream "255 256 " -> single push of 255; after "256 ", err=1 and no second strobe; "999-" additionally produces only (op4) with err=1.
- Stream "4x5 " -> 'x' sets err=1 and discards 4; then push (op0, 5); no strobe for 4.
- Stream "12" then reset low for 1 cycle mid-literal, then " 9 d" -> outputs cleared immediately on reset assert, err=0; afterwards only push (op0, 9) then (op1); no push of 12.
- Stream "  +  " with in_valid toggling every other cycle -> exactly one strobe (op2); separators produce no strobes; in_ready is never low outside the emit cycle.
